instruction_fetch_responder: RTL

INSTRUCTION_FETCH_RESPONDER -- requirements
Module: instruction_fetch_responder

---
 rtl/instruction_fetch_responder_pkg.sv | 31 +++
 rtl/instruction_fetch_responder.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_responder_pkg.sv
// ---------------------------------------------------------------------------
// instruction_fetch_responder_pkg
//   Shared configuration, state encoding and payload types for the
//   instruction fetch responder (line buffer in front of a 32-bit memory).
//   No ports: types and constants only.
// ---------------------------------------------------------------------------
package instruction_fetch_responder_pkg;

   // ---- Configuration ----------------------------------------------------
   localparam int LINE_WORDS           = 4;   // 32-bit words per 128-bit line
   localparam int LINE_ENTRIES_DEFAULT = 2;   // line-buffer entries (power of two, >= 2)
   localparam int WORD_W               = 32;
   localparam int LINE_W               = LINE_WORDS * WORD_W;
   localparam int BEAT_W               = $clog2(LINE_WORDS);
   localparam int TAG_W                = 28;  // address bits [31:4]

   // ---- Enumerations -----------------------------------------------------
   typedef enum logic [1:0] {
      IDLE,   // no memory traffic; misses are evaluated here only
      FILL,   // fetching the four beats of a line
      DRAIN   // fill abandoned, waiting for the ack of the held beat
   } FetchResponderState_;

   // ---- Payloads ---------------------------------------------------------
   typedef struct packed {
      logic              valid;
      logic [TAG_W-1:0]  tag;
      logic [LINE_W-1:0] data;
   } LineBufferEntry_;

endpackage

// File: rtl/instruction_fetch_responder.sv
// ---------------------------------------------------------------------------
// instruction_fetch_responder
//   Small fully associative line buffer that answers 16-byte-aligned fetch
//   requests one cycle after they are presented and refills missing lines
//   from a 32-bit memory port, one beat at a time, round-robin replacement.
//
// Ports
//   clock                      rising-edge clock
//   reset                      asynchronous, active-low
//   alignedAddress[31:0]       requested line address (bits [3:0] ignored)
//   redirect                   front-end flush: abandons the in-flight fill
//   instructionFetchData[127:0] registered line, word k at bits [32k+31:32k]
//   instructionFetchDataValid  line data valid for the previous-edge address
//   memoryRequest              a 32-bit read beat is pending
//   memoryAddress[31:0]        word address of the pending beat
//   memoryReadData[31:0]       beat data, valid while memoryAck=1
//   memoryAck                  beat completes on an edge with request & ack
// ---------------------------------------------------------------------------
module instruction_fetch_responder
   import instruction_fetch_responder_pkg::*;
#(
   parameter int LINE_ENTRIES = LINE_ENTRIES_DEFAULT
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [31:0]       alignedAddress,
   input  logic              redirect,
   output logic [LINE_W-1:0] instructionFetchData,
   output logic              instructionFetchDataValid,
   output logic              memoryRequest,
   output logic [31:0]       memoryAddress,
   input  logic [31:0]       memoryReadData,
   input  logic              memoryAck
);

   localparam int              VICTIM_W  = $clog2(LINE_ENTRIES);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

   LineBufferEntry_                    entries [LINE_ENTRIES];
   FetchResponderState_                state;
   FetchResponderState_                state_next;
   logic [TAG_W-1:0]                   fill_tag;
   logic [BEAT_W-1:0]                  beat_count;
   logic [VICTIM_W-1:0]                victim;
   logic [LINE_WORDS-1:0][WORD_W-1:0]  staging;
   logic [LINE_WORDS-1:0][WORD_W-1:0]  completed_line;

   logic              lookup_hit;
   logic [LINE_W-1:0] lookup_data;
   logic              tag_present;
   logic              start_fill;
   logic              take_beat;
   logic              commit_line;
   logic              clear_beat;

   // Offset bits of the line address carry no information.
   logic addr_offset_unused;
   assign addr_offset_unused = ^alignedAddress[3:0];

   // ---- Lookup and duplicate detection -----------------------------------
   // NOTE: every combinational output gets a default first so no path leaves
   // it unassigned, which would otherwise infer a latch.
   always_comb begin
      lookup_hit  = 1'b0;
      lookup_data = '0;
      tag_present = 1'b0;
      for (int i = 0; i < LINE_ENTRIES; i++) begin
         if (entries[i].valid && entries[i].tag == alignedAddress[31:4]) begin
            lookup_hit  = 1'b1;
            lookup_data = entries[i].data;
         end
         if (entries[i].valid && entries[i].tag == fill_tag) begin
            tag_present = 1'b1;
         end
      end
   end

   // The last beat is written straight from the memory bus on the commit edge.
   always_comb begin
      completed_line            = staging;
      completed_line[LAST_BEAT] = memoryReadData;
   end

   // ---- State machine: next state and control strobes --------------------
   always_comb begin
      state_next  = state;
      start_fill  = 1'b0;
      take_beat   = 1'b0;
      commit_line = 1'b0;
      clear_beat  = 1'b0;
      case (state)
         IDLE: begin
            if (!redirect && !lookup_hit) begin
               state_next = FILL;
               start_fill = 1'b1;
            end
         end
         FILL: begin
            if (redirect) begin
               // With an ack the beat is simply dropped; without one the
               // memory still owns a request that must be allowed to finish.
               state_next = memoryAck ? IDLE : DRAIN;
               clear_beat = memoryAck;
            end else if (memoryAck) begin
               take_beat = 1'b1;
               if (beat_count == LAST_BEAT) begin
                  commit_line = 1'b1;
                  state_next  = IDLE;
               end
            end
         end
         DRAIN: begin
            if (memoryAck) begin
               state_next = IDLE;
               clear_beat = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // ---- State register ---------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_next;
   end

   // ---- Fill datapath and line buffer ------------------------------------
   // NOTE: the whole entry array is reset, not just the valid bits, so every
   // flop in this block shares the same asynchronous reset.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < LINE_ENTRIES; i++) entries[i] <= '0;
         fill_tag   <= '0;
         beat_count <= '0;
         victim     <= '0;
         staging    <= '0;
      end else begin
         if (start_fill) begin
            fill_tag   <= alignedAddress[31:4];
            beat_count <= '0;
         end
         if (take_beat) begin
            staging[beat_count] <= memoryReadData;
            beat_count          <= beat_count + BEAT_W'(1);
         end
         if (clear_beat) beat_count <= '0;
         if (commit_line && !tag_present) begin
            entries[victim] <= '{valid: 1'b1, tag: fill_tag, data: completed_line};
            victim          <= victim + VICTIM_W'(1);
         end
      end
   end

   // ---- Registered fetch response ----------------------------------------
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         instructionFetchData      <= '0;
         instructionFetchDataValid <= 1'b0;
      end else begin
         instructionFetchDataValid <= !redirect && lookup_hit;
         if (!redirect && lookup_hit) instructionFetchData <= lookup_data;
      end
   end

   // ---- Memory port (decoded from registers only) ------------------------
   assign memoryRequest = (state != IDLE);
   assign memoryAddress = memoryRequest ? {fill_tag, beat_count, 2'b00} : '0;

endmodule
